// File: rtl/reg_file_ctrl.sv
// Register-file write-port controller: post-reset clear sweep, x0 write masking,
// and arbitration of the write port / read port 1 between core writeback and debug.
module reg_file_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int NREGS      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] core_a1,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              core_stall,
    output logic              init_done,
    output logic [ADDR_W-1:0] rf_a1,
    input  logic [DATA_W-1:0] rf_rd1,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              rf_we3
);

    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [ADDR_W-1:0] SWEEP_LAST  = ADDR_W'(NREGS - 1);
    localparam logic [SW-1:0]     STARVE_LAST = SW'(STARVE_MAX - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              init_done_q, init_done_d;
    logic              gnt_q, gnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_gnt, wr_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            starve_q    <= '0;
            init_done_q <= 1'b0;
            gnt_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            starve_q    <= starve_d;
            init_done_q <= init_done_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        starve_d    = starve_q;
        init_done_d = init_done_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        rd_gnt      = 1'b0;
        wr_gnt      = 1'b0;
        dbg_gnt     = 1'b0;
        core_stall  = 1'b0;
        rf_a1       = core_a1;
        rf_a3       = wb_addr;
        rf_wd3      = wb_data;
        rf_we3      = 1'b0;

        unique case (state_q)
            S_INIT: begin
                // rst gates the write so nothing lands in the array while reset is held
                rf_we3     = rst;
                rf_a3      = sweep_q;
                rf_wd3     = '0;
                core_stall = 1'b1;
                sweep_d    = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                    sweep_d     = '0;
                end
            end
            S_RUN: begin
                // gnt_q blocks a second grant to a request still held after its grant
                rd_gnt = dbg_req && !dbg_we && !gnt_q;
                wr_gnt = dbg_req && dbg_we && !gnt_q &&
                         (!wb_we || (starve_q == STARVE_LAST));
                rf_we3 = wb_we && (wb_addr != '0);
                if (rd_gnt) begin
                    dbg_gnt    = 1'b1;
                    core_stall = 1'b1;
                    rf_a1      = dbg_addr;
                    rvalid_d   = 1'b1;
                    rdata_d    = rf_rd1;
                end
                if (wr_gnt) begin
                    dbg_gnt    = 1'b1;
                    core_stall = wb_we;
                    rf_a3      = dbg_addr;
                    rf_wd3     = dbg_wdata;
                    rf_we3     = (dbg_addr != '0);
                end
                if (dbg_req && dbg_we && !wr_gnt) begin
                    starve_d = (starve_q == STARVE_LAST) ? starve_q : starve_q + 1'b1;
                end else begin
                    starve_d = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    assign gnt_d      = dbg_gnt;
    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a behavioural 32x32 register array
// attached to the rf_* ports.
module tb_reg_file_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  core_a1 = '0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid, core_stall, init_done, rf_we3;
    logic [31:0] dbg_rdata, rf_rd1, rf_wd3;
    logic [4:0]  rf_a1, rf_a3;

    int tests = 0;
    int failed = 0;
    logic preload = 1'b0;
    logic [31:0] mem [32];

    always #5 clk = ~clk;

    reg_file_ctrl #(.ADDR_W(5), .DATA_W(32), .NREGS(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .core_a1(core_a1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .core_stall(core_stall), .init_done(init_done),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3)
    );

    assign rf_rd1 = mem[rf_a1];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hDEADBEEF;
        end else if (rf_we3) begin
            mem[rf_a3] <= rf_wd3;
        end
    end

    task automatic test_reset();
        logic [40:0] got_v, exp_v;
        int nz;
        rst = 1'b0; preload = 1'b1;
        @(negedge clk); preload = 1'b0; #1;
        tests++; if (rf_we3 !== 1'b0) begin failed++; $display("FAIL reset_we3: got %b expected 0", rf_we3); end
        tests++; if ({init_done, dbg_gnt, dbg_rvalid} !== 3'b000) begin failed++; $display("FAIL reset_flags: got %b expected 000", {init_done, dbg_gnt, dbg_rvalid}); end
        tests++; if (dbg_rdata !== 32'h0) begin failed++; $display("FAIL reset_rdata: got %h expected 0", dbg_rdata); end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            got_v = {rf_we3, rf_a3, rf_wd3, core_stall, dbg_gnt, init_done};
            exp_v = {1'b1, 5'(i), 32'h0, 1'b1, 1'b0, 1'b0};
            tests++; if (got_v !== exp_v) begin failed++; $display("FAIL sweep[%0d]: got %h expected %h", i, got_v, exp_v); end
            @(negedge clk);
        end
        #1;
        tests++; if (init_done !== 1'b1) begin failed++; $display("FAIL init_done_rise: got %b expected 1", init_done); end
        tests++; if (core_stall !== 1'b0) begin failed++; $display("FAIL run_stall: got %b expected 0", core_stall); end
        nz = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== 32'h0) nz++;
        tests++; if (nz !== 0) begin failed++; $display("FAIL array_cleared: got %0d nonzero expected 0", nz); end
    endtask

    task automatic test_wb_write();
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678; core_a1 = 5'd3; #1;
        tests++; if (rf_we3 !== 1'b0) begin failed++; $display("FAIL wb_x0_we3: got %b expected 0", rf_we3); end
        tests++; if (rf_a1 !== 5'd3) begin failed++; $display("FAIL run_a1: got %0d expected 3", rf_a1); end
        @(negedge clk);
        tests++; if (mem[0] !== 32'h0) begin failed++; $display("FAIL x0_stays_zero: got %h expected 0", mem[0]); end
        wb_addr = 5'd5; #1;
        tests++; if ({rf_we3, rf_a3, rf_wd3} !== {1'b1, 5'd5, 32'h12345678}) begin failed++; $display("FAIL wb_x5_port: got %h expected %h", {rf_we3, rf_a3, rf_wd3}, {1'b1, 5'd5, 32'h12345678}); end
        @(negedge clk); wb_we = 1'b0;
        tests++; if (mem[5] !== 32'h12345678) begin failed++; $display("FAIL wb_x5_value: got %h expected 12345678", mem[5]); end
    endtask

    task automatic test_dbg_read();
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h11; core_a1 = 5'd2;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5; #1;
        tests++; if ({dbg_gnt, core_stall} !== 2'b11) begin failed++; $display("FAIL rd_gnt_stall: got %b expected 11", {dbg_gnt, core_stall}); end
        tests++; if (rf_a1 !== 5'd5) begin failed++; $display("FAIL rd_a1: got %0d expected 5", rf_a1); end
        tests++; if ({rf_we3, rf_a3} !== {1'b1, 5'd9}) begin failed++; $display("FAIL rd_core_port: got %h expected %h", {rf_we3, rf_a3}, {1'b1, 5'd9}); end
        @(negedge clk); dbg_req = 1'b0; wb_we = 1'b0; #1;
        tests++; if (dbg_rvalid !== 1'b1) begin failed++; $display("FAIL rd_rvalid: got %b expected 1", dbg_rvalid); end
        tests++; if (dbg_rdata !== 32'h12345678) begin failed++; $display("FAIL rd_rdata: got %h expected 12345678", dbg_rdata); end
        tests++; if ({dbg_gnt, rf_a1} !== {1'b0, 5'd2}) begin failed++; $display("FAIL rd_release: got %h expected %h", {dbg_gnt, rf_a1}, {1'b0, 5'd2}); end
        @(negedge clk); #1;
        tests++; if (dbg_rvalid !== 1'b0) begin failed++; $display("FAIL rd_rvalid_pulse: got %b expected 0", dbg_rvalid); end
    endtask

    task automatic test_dbg_write_starve();
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hCAFEF00D;
        for (int k = 1; k <= 3; k++) begin
            #1;
            tests++; if ({dbg_gnt, core_stall, rf_we3, rf_wd3} !== {3'b001, 32'h77}) begin failed++; $display("FAIL starve_wait[%0d]: got %h expected %h", k, {dbg_gnt, core_stall, rf_we3, rf_wd3}, {3'b001, 32'h77}); end
            @(negedge clk);
        end
        #1;
        tests++; if ({dbg_gnt, core_stall, rf_we3} !== 3'b111) begin failed++; $display("FAIL starve_gnt: got %b expected 111", {dbg_gnt, core_stall, rf_we3}); end
        tests++; if ({rf_a3, rf_wd3} !== {5'd7, 32'hCAFEF00D}) begin failed++; $display("FAIL starve_port: got %h expected %h", {rf_a3, rf_wd3}, {5'd7, 32'hCAFEF00D}); end
        @(negedge clk); dbg_req = 1'b0;
        tests++; if (mem[7] !== 32'hCAFEF00D) begin failed++; $display("FAIL starve_x7: got %h expected cafef00d", mem[7]); end
        #1;
        tests++; if ({dbg_gnt, core_stall, rf_wd3} !== {2'b00, 32'h77}) begin failed++; $display("FAIL starve_after: got %h expected %h", {dbg_gnt, core_stall, rf_wd3}, {2'b00, 32'h77}); end
        @(negedge clk); wb_we = 1'b0;
        tests++; if (mem[7] !== 32'h77) begin failed++; $display("FAIL starve_core_lands: got %h expected 77", mem[7]); end
    endtask

    task automatic test_dbg_write_idle();
        @(negedge clk);
        wb_we = 1'b0; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hA5A5A5A5; #1;
        tests++; if ({dbg_gnt, core_stall, rf_we3, rf_a3} !== {3'b101, 5'd9}) begin failed++; $display("FAIL idle_gnt: got %h expected %h", {dbg_gnt, core_stall, rf_we3, rf_a3}, {3'b101, 5'd9}); end
        @(negedge clk); #1;
        tests++; if ({dbg_gnt, rf_we3} !== 2'b00) begin failed++; $display("FAIL back_to_back: got %b expected 00", {dbg_gnt, rf_we3}); end
        @(negedge clk); dbg_req = 1'b0;
        tests++; if (mem[9] !== 32'hA5A5A5A5) begin failed++; $display("FAIL idle_x9: got %h expected a5a5a5a5", mem[9]); end
        @(negedge clk); dbg_req = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFFFFFF; #1;
        tests++; if ({dbg_gnt, rf_we3} !== 2'b10) begin failed++; $display("FAIL dbg_x0: got %b expected 10", {dbg_gnt, rf_we3}); end
        @(negedge clk); dbg_req = 1'b0;
        tests++; if (mem[0] !== 32'h0) begin failed++; $display("FAIL dbg_x0_value: got %h expected 0", mem[0]); end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9; #1;
        tests++; if (dbg_gnt !== 1'b1) begin failed++; $display("FAIL pre_rst_gnt: got %b expected 1", dbg_gnt); end
        #1 rst = 1'b0; #1;
        tests++; if ({dbg_gnt, rf_we3, init_done} !== 3'b000) begin failed++; $display("FAIL rst_drop_gnt: got %b expected 000", {dbg_gnt, rf_we3, init_done}); end
        @(negedge clk); dbg_req = 1'b0; #1;
        tests++; if ({dbg_rvalid, dbg_rdata} !== 33'h0) begin failed++; $display("FAIL rst_rvalid: got %h expected 0", {dbg_rvalid, dbg_rdata}); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [40:0] got_v, exp_v;
        preload = 1'b1;
        @(negedge clk); preload = 1'b0; rst = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        tests++; if ({rf_we3, rf_a3} !== {1'b1, 5'd10}) begin failed++; $display("FAIL sweep_idx10: got %h expected %h", {rf_we3, rf_a3}, {1'b1, 5'd10}); end
        rst = 1'b0; #1;
        tests++; if ({rf_we3, init_done} !== 2'b00) begin failed++; $display("FAIL midsweep_rst: got %b expected 00", {rf_we3, init_done}); end
        @(negedge clk);
        tests++; if ({mem[9], mem[10]} !== {32'h0, 32'hDEADBEEF}) begin failed++; $display("FAIL no_write_in_rst: got %h expected %h", {mem[9], mem[10]}, {32'h0, 32'hDEADBEEF}); end
        rst = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd10;
        for (int i = 0; i < 32; i++) begin
            #1;
            got_v = {rf_we3, rf_a3, rf_wd3, core_stall, dbg_gnt, init_done};
            exp_v = {1'b1, 5'(i), 32'h0, 1'b1, 1'b0, 1'b0};
            tests++; if (got_v !== exp_v) begin failed++; $display("FAIL resweep[%0d]: got %h expected %h", i, got_v, exp_v); end
            @(negedge clk);
        end
        #1;
        tests++; if ({dbg_gnt, core_stall, init_done} !== 3'b111) begin failed++; $display("FAIL first_run_gnt: got %b expected 111", {dbg_gnt, core_stall, init_done}); end
        @(negedge clk); dbg_req = 1'b0; #1;
        tests++; if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'h0}) begin failed++; $display("FAIL resweep_read_x10: got %h expected %h", {dbg_rvalid, dbg_rdata}, {1'b1, 32'h0}); end
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_dbg_read();
        test_dbg_write_starve();
        test_dbg_write_idle();
        test_reset_mid_access();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
